data_memory: RTL and testbench

Word-organised backing store that answers the data cache's miss/write-back requests over the `interupt_start`/`interupt_stop` handshake. It is the responder end of the cache's memory port. It latches one request, waits a programmable access latency, performs the read or write, then pulses completion with read data valid. It sits between the data cache and nothing else; it is the bottom of the memory hierarchy.

---
 rtl/data_memory.sv | 175 +++++++++++++++++
 tb/tb_data_memory.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-organised backing store at the bottom of the memory
// hierarchy. It answers one cache request at a time over the
// interupt_start / interupt_stop handshake.
//
// Request lifecycle:
//   - Latch the request.
//   - Wait LATENCY cycles.
//   - Commit the read or write.
//   - Pulse interupt_stop for one cycle, with mem_err for out-of-range accesses.
//
// Storage contents survive reset.

module data_memory #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [7:0]  mem_data_in [0:3],
    input  logic        interupt_start,
    output logic [7:0]  mem_data_out [0:3],
    output logic        interupt_stop,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [ADDR_W-1:0]      idx_q,    idx_d;
    logic                   we_q,     we_d;
    logic                   oor_q,    oor_d;
    logic [3:0][7:0]        wdata_q,  wdata_d;
    logic [3:0][7:0]        dout_q,   dout_d;
    logic                   stop_q,   stop_d;
    logic                   err_q,    err_d;
    logic                   busy_q,   busy_d;

    // Backing store: deliberately outside the reset domain so contents persist.
    logic [3:0][7:0]        store_q [0:DEPTH_WORDS-1];

    logic                   commit_s;
    logic                   store_we_s;
    logic [3:0][7:0]        rd_word_s;
    logic                   req_oor_s;
    logic [3:0][7:0]        req_data_s;
    logic                   unused_addr_s;

    // Byte-offset bits never select anything; word granularity only.
    assign unused_addr_s = ^mem_addr[1:0];

    // Classify and pack the incoming request so it can be latched in one step.
    always_comb begin
        req_oor_s = |mem_addr[31:ADDR_W+2];
        for (int i = 0; i < 4; i++) begin
            req_data_s[i] = mem_data_in[i];
        end
    end

    // Commit strobe and gated store write-enable (forced off while in reset via state).
    always_comb begin
        commit_s   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(0));
        store_we_s = commit_s && we_q && !oor_q;
        rd_word_s  = store_q[idx_q];
    end

    // Next-state and next-output logic for the request handshake FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        stop_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (interupt_start) begin
                    idx_d   = mem_addr[ADDR_W+1:2];
                    we_d    = mem_we;
                    oor_d   = req_oor_s;
                    wdata_d = req_data_s;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    stop_d  = 1'b1;
                    err_d   = oor_q;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        dout_d = oor_q ? 32'h0000_0000 : rd_word_s;
                    end else begin
                        dout_d = dout_q;
                    end
                end
            end
            ST_DONE: begin
                // The cache must drop start once before a new request is taken.
                if (interupt_start) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_W'(0);
            idx_q   <= ADDR_W'(0);
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
            dout_q  <= 32'h0000_0000;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage write port: one word per in-range write commit.
    always_ff @(posedge clk) begin
        if (store_we_s) begin
            store_q[idx_q] <= wdata_q;
        end
    end

    // Drive the byte-lane outputs straight from their registers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_out[i] = dout_q[i];
        end
        interupt_stop = stop_q;
        mem_busy      = busy_q;
        mem_err       = err_q;
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory with a word-array reference model.
module tb_data_memory;

    localparam int DEPTH_WORDS = 4096;
    localparam int LATENCY     = 4;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  din  [0:3];
    logic        start;
    logic [7:0]  dout [0:3];
    logic        stop;
    logic        busy;
    logic        err;

    data_memory #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_data_in    (din),
        .interupt_start (start),
        .mem_data_out   (dout),
        .interupt_stop  (stop),
        .mem_busy       (busy),
        .mem_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: plain word array plus the value the output port should hold.
    logic [31:0] model_mem [0:DEPTH_WORDS-1];
    logic [31:0] last_out = 32'h0;

    int checks   = 0;
    int failures = 0;
    logic prev_stop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dout_word();
        return {dout[3], dout[2], dout[1], dout[0]};
    endfunction

    task automatic set_data(input logic [31:0] d);
        for (int i = 0; i < 4; i++) din[i] = d[i*8 +: 8];
    endtask

    task automatic scramble();
        mem_addr = $urandom;
        mem_we   = 1'($urandom);
        set_data($urandom);
    endtask

    // Monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (prev_stop) chk("stop_one_cycle", {31'b0, stop}, 32'd0);
        if (!stop) chk("err_without_stop", {31'b0, err}, 32'd0);
        if (stop) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_stop", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("stop_cycle", cyc, e.cyc);
                chk("err", {31'b0, err}, {31'b0, e.err});
                chk("data_out", dout_word(), e.data);
                chk("busy_at_stop", {31'b0, busy}, 32'd1);
            end
        end
        prev_stop = stop;
    end

    task automatic hold_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        scramble();
        last_out = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_stop", {31'b0, stop}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_err",  {31'b0, err},  32'd0);
            chk("rst_dout", dout_word(), 32'd0);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int hold, input bit abort);
        exp_t e;
        bit   oor;
        bit   seen;
        int   widx;
        @(negedge clk);
        reset    = 1'b1;
        mem_addr = a;
        mem_we   = w;
        set_data(d);
        start    = 1'b1;
        oor  = longint'(a) >= longint'(DEPTH_WORDS) * 4;
        widx = int'(a / 4) % DEPTH_WORDS;
        if (abort) begin
            repeat (2) begin
                @(negedge clk);
                scramble();
            end
            reset = 1'b0;
            last_out = 32'h0;
            repeat (2) @(negedge clk);
            chk("abort_busy", {31'b0, busy}, 32'd0);
            chk("abort_dout", dout_word(), 32'd0);
            reset = 1'b1;
            start = 1'b0;
            return;
        end
        if (w) begin
            if (!oor) model_mem[widx] = d;
        end else begin
            last_out = oor ? 32'h0 : model_mem[widx];
        end
        e.cyc  = cyc + 1 + LATENCY;
        e.data = last_out;
        e.err  = oor;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < LATENCY + 6; i++) begin
            @(negedge clk);
            if (stop) begin
                seen = 1'b1;
                break;
            end
            scramble();
        end
        if (!seen) begin
            chk("stop_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble();
            chk("hold_busy", {31'b0, busy}, 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r;
        reset = 1'b0;
        start = 1'b0;
        mem_addr = 32'h0;
        mem_we = 1'b0;
        set_data(32'h0);
        for (int i = 0; i < DEPTH_WORDS; i++) model_mem[i] = 32'h0;

        // Reset held with start high: nothing accepted, outputs zero.
        hold_reset(3);

        // Known contents for every word the bench later reads.
        for (int i = 0; i < 32; i++) req(32'(i * 4), 1'b1, $urandom, 0, 1'b0);
        req(32'h0000_3FFC, 1'b1, 32'hA5A5_5A5A, 0, 1'b0);
        req(32'h0000_3FFF, 1'b0, 32'h0, 0, 1'b0);

        // Write then read with a non-zero byte offset.
        req(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        req(32'h0000_0013, 1'b0, 32'h0, 0, 1'b0);

        // Input changes during BUSY must be ignored.
        req(32'h0000_0020, 1'b1, 32'h1122_3344, 0, 1'b0);
        req(32'h0000_0020, 1'b0, 32'h0, 0, 1'b0);
        req(32'h0000_0040, 1'b0, 32'h0, 0, 1'b0);

        // Start held through DONE: no second acceptance.
        req(32'h0000_0010, 1'b0, 32'h0, 5, 1'b0);
        req(32'h0000_0024, 1'b0, 32'h0, 0, 1'b0);

        // Out-of-range read and write.
        req(32'h0001_0000, 1'b0, 32'h0, 0, 1'b0);
        req(32'h0001_0000, 1'b1, 32'h9999_8888, 0, 1'b0);
        req(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0);

        // Reset in the middle of a write drops it.
        req(32'h0000_0008, 1'b1, 32'hCAFE_F00D, 0, 1'b1);
        req(32'h0000_0008, 1'b0, 32'h0, 0, 1'b0);

        // A completed write survives reset.
        req(32'h0000_0008, 1'b1, 32'h0BAD_CAFE, 0, 1'b0);
        hold_reset(2);
        req(32'h0000_0008, 1'b0, 32'h0, 0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = (32'($urandom_range(1, 32'h3FFFF)) << 14) | (32'($urandom) & 32'h3FFF);
            else        a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            req(a, 1'($urandom), $urandom, $urandom_range(0, 3), r == 9);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
